// File: rtl/frame_config_fsm_pkg.sv
// Shared definitions for the frame configuration FSM: state encoding,
// default sync word and the bit positions of the address word fields.
// Optional feature macro: FRAME_CFG_CHECKSUM_EN adds the CHECK state.
package frame_config_fsm_pkg;

   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

   // Address word layout: bit 31 marks desync, [23:16] column, [4:0] index.
   localparam int DESYNC_BIT = 31;
   localparam int COL_MSB    = 23;
   localparam int COL_LSB    = 16;
   localparam int IDX_MSB    = 4;
   localparam int IDX_LSB    = 0;
   localparam int COL_W      = 8;
   localparam int IDX_W      = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
`ifdef FRAME_CFG_CHECKSUM_EN
      ST_DATA  = 2'd2,
      ST_CHECK = 2'd3
`else
      ST_DATA  = 2'd2
`endif
   } cfg_state_e;

endpackage

// File: rtl/frame_cfg_checksum.sv
// Running XOR accumulator over configuration words. A clear restarts the
// sum at zero; clear has priority over enable.
module frame_cfg_checksum (
   input  logic        clk,
   input  logic        resetn,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] din,
   output logic [31:0] sum
);

   logic [31:0] sum_q;
   logic [31:0] sum_d;

   // Next accumulator value: clear, fold in a word, or hold.
   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = 32'd0;
      end else if (en) begin
         sum_d = sum_q ^ din;
      end else begin
         sum_d = sum_q;
      end
   end

   // Accumulator register with asynchronous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sum_q <= 32'd0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/frame_config_fsm.sv
// Frame configuration FSM: opens a session on the sync word, then takes
// address/data word pairs and emits one registered frame per pair. A word
// with bit 31 set closes the session and re-enables fabric outputs.
// Optional feature macro: FRAME_CFG_CHECKSUM_EN -- the word after desync must
// equal the XOR of all address/data words of the session.
module frame_config_fsm
   import frame_config_fsm_pkg::*;
#(
   parameter int          FrameBitsPerRow = 32,
   parameter int          MaxFramesPerCol = 20,
   parameter logic [31:0] SyncWord        = SYNC_WORD_DEFAULT
) (
   input  logic                       UserCLK,
   input  logic                       resetn,
   input  logic [31:0]                WriteData,
   input  logic                       WriteStrobe,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [COL_W-1:0]           FrameCol,
   output logic [IDX_W-1:0]           FrameIdx,
   output logic                       FrameStrobe,
   output logic                       ConfigActive,
   output logic                       OutputEnable,
   output logic                       ConfigError
);

   // Indices at or above this bound address no real frame.
   localparam logic [IDX_W:0] MAX_IDX = (IDX_W+1)'(MaxFramesPerCol);

   cfg_state_e                 state_q, state_d;
   logic [COL_W-1:0]           col_q, col_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
   logic [COL_W-1:0]           frame_col_q, frame_col_d;
   logic [IDX_W-1:0]           frame_idx_q, frame_idx_d;
   logic                       frame_strobe_q, frame_strobe_d;
   logic                       active_q, active_d;
   logic                       oe_q, oe_d;
   logic                       err_q, err_d;

`ifdef FRAME_CFG_CHECKSUM_EN
   logic        cks_clr_s;
   logic        cks_en_s;
   logic [31:0] cks_sum_s;

   frame_cfg_checksum u_checksum (
      .clk    (UserCLK),
      .resetn (resetn),
      .clr    (cks_clr_s),
      .en     (cks_en_s),
      .din    (WriteData),
      .sum    (cks_sum_s)
   );
`endif

   // Next-state and output decode; every register holds unless a strobed word acts on it.
   always_comb begin
      state_d        = state_q;
      col_d          = col_q;
      idx_d          = idx_q;
      frame_data_d   = frame_data_q;
      frame_col_d    = frame_col_q;
      frame_idx_d    = frame_idx_q;
      frame_strobe_d = 1'b0;
      active_d       = active_q;
      oe_d           = oe_q;
      err_d          = err_q;
`ifdef FRAME_CFG_CHECKSUM_EN
      cks_clr_s      = 1'b0;
      cks_en_s       = 1'b0;
`endif
      if (WriteStrobe) begin
         case (state_q)
            ST_IDLE: begin
               if (WriteData == SyncWord) begin
                  state_d  = ST_ADDR;
                  active_d = 1'b1;
                  oe_d     = 1'b0;
                  err_d    = 1'b0;
`ifdef FRAME_CFG_CHECKSUM_EN
                  cks_clr_s = 1'b1;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (WriteData[DESYNC_BIT]) begin
`ifdef FRAME_CFG_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  // Error is sticky for the session, so outputs stay off.
                  state_d  = ST_IDLE;
                  active_d = 1'b0;
                  oe_d     = ~err_q;
`endif
               end else begin
                  col_d   = WriteData[COL_MSB:COL_LSB];
                  idx_d   = WriteData[IDX_MSB:IDX_LSB];
                  state_d = ST_DATA;
`ifdef FRAME_CFG_CHECKSUM_EN
                  cks_en_s = 1'b1;
`endif
               end
            end
            ST_DATA: begin
               state_d = ST_ADDR;
`ifdef FRAME_CFG_CHECKSUM_EN
               cks_en_s = 1'b1;
`endif
               if ({1'b0, idx_q} >= MAX_IDX) begin
                  err_d = 1'b1;
               end else begin
                  frame_data_d   = WriteData[FrameBitsPerRow-1:0];
                  frame_col_d    = col_q;
                  frame_idx_d    = idx_q;
                  frame_strobe_d = 1'b1;
               end
            end
`ifdef FRAME_CFG_CHECKSUM_EN
            ST_CHECK: begin
               state_d  = ST_IDLE;
               active_d = 1'b0;
               if (WriteData == cks_sum_s) begin
                  oe_d = ~err_q;
               end else begin
                  err_d = 1'b1;
                  oe_d  = 1'b0;
               end
            end
`endif
            default: begin
               state_d  = ST_IDLE;
               active_d = 1'b0;
               oe_d     = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers; reset drops everything to a quiet, disabled fabric.
   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         col_q          <= '0;
         idx_q          <= '0;
         frame_data_q   <= '0;
         frame_col_q    <= '0;
         frame_idx_q    <= '0;
         frame_strobe_q <= 1'b0;
         active_q       <= 1'b0;
         oe_q           <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         col_q          <= col_d;
         idx_q          <= idx_d;
         frame_data_q   <= frame_data_d;
         frame_col_q    <= frame_col_d;
         frame_idx_q    <= frame_idx_d;
         frame_strobe_q <= frame_strobe_d;
         active_q       <= active_d;
         oe_q           <= oe_d;
         err_q          <= err_d;
      end
   end

   assign FrameData    = frame_data_q;
   assign FrameCol     = frame_col_q;
   assign FrameIdx     = frame_idx_q;
   assign FrameStrobe  = frame_strobe_q;
   assign ConfigActive = active_q;
   assign OutputEnable = oe_q;
   assign ConfigError  = err_q;

endmodule

// File: tb/tb_frame_config_fsm.sv
// Directed bench for frame_config_fsm. Expected frames go into a queue as
// data words are issued; a monitor pops and compares on every FrameStrobe.
module tb_frame_config_fsm;

   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic        UserCLK;
   logic        resetn;
   logic [31:0] WriteData;
   logic        WriteStrobe;
   logic [31:0] FrameData;
   logic [7:0]  FrameCol;
   logic [4:0]  FrameIdx;
   logic        FrameStrobe;
   logic        ConfigActive;
   logic        OutputEnable;
   logic        ConfigError;

   typedef struct packed {
      logic [7:0]  col;
      logic [4:0]  idx;
      logic [31:0] data;
   } frame_t;

   frame_t      exp_q[$];
   frame_t      mon_e;
   int          checks;
   int          errors;
   logic [31:0] cks;

   frame_config_fsm #(
      .FrameBitsPerRow (32),
      .MaxFramesPerCol (20),
      .SyncWord        (SYNC)
   ) dut (
      .UserCLK      (UserCLK),
      .resetn       (resetn),
      .WriteData    (WriteData),
      .WriteStrobe  (WriteStrobe),
      .FrameData    (FrameData),
      .FrameCol     (FrameCol),
      .FrameIdx     (FrameIdx),
      .FrameStrobe  (FrameStrobe),
      .ConfigActive (ConfigActive),
      .OutputEnable (OutputEnable),
      .ConfigError  (ConfigError)
   );

   initial UserCLK = 1'b0;
   always #5 UserCLK = ~UserCLK;

   // Frame monitor: every strobe must match the oldest expected frame.
   always @(negedge UserCLK) begin
      if (resetn && FrameStrobe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe got col=%0d idx=%0d data=%h required no strobe",
                     FrameCol, FrameIdx, FrameData);
         end else begin
            mon_e = exp_q.pop_front();
            if (FrameCol !== mon_e.col || FrameIdx !== mon_e.idx || FrameData !== mon_e.data) begin
               errors++;
               $display("FAIL frame got col=%0d idx=%0d data=%h required col=%0d idx=%0d data=%h",
                        FrameCol, FrameIdx, FrameData, mon_e.col, mon_e.idx, mon_e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   // Drive one strobed word; returns at the next falling edge with its effect visible.
   task automatic send(input logic [31:0] w);
      WriteData   = w;
      WriteStrobe = 1'b1;
      @(negedge UserCLK);
      WriteStrobe = 1'b0;
   endtask

   // Address/data word that also feeds the bench's checksum model.
   task automatic word(input logic [31:0] w);
      cks = cks ^ w;
      send(w);
   endtask

   task automatic open_session();
      cks = 32'd0;
      send(SYNC);
   endtask

   task automatic push(input logic [7:0] c, input logic [4:0] i, input logic [31:0] d);
      frame_t f;
      f.col  = c;
      f.idx  = i;
      f.data = d;
      exp_q.push_back(f);
   endtask

   task automatic idle(input int n);
      WriteStrobe = 1'b0;
      repeat (n) begin
         WriteData = $urandom;
         @(negedge UserCLK);
      end
   endtask

   task automatic end_session(input logic exp_oe, input logic exp_err);
      send(32'h8000_0000);
`ifdef FRAME_CFG_CHECKSUM_EN
      chk("active_in_check", {31'd0, ConfigActive}, 32'd1);
      chk("oe_in_check", {31'd0, OutputEnable}, 32'd0);
      send(cks);
`endif
      chk("active_after_desync", {31'd0, ConfigActive}, 32'd0);
      chk("oe_after_desync", {31'd0, OutputEnable}, {31'd0, exp_oe});
      chk("err_after_desync", {31'd0, ConfigError}, {31'd0, exp_err});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_strobe"}, {31'd0, FrameStrobe}, 32'd0);
      chk({tag, "_data"}, FrameData, 32'd0);
      chk({tag, "_col"}, {24'd0, FrameCol}, 32'd0);
      chk({tag, "_idx"}, {27'd0, FrameIdx}, 32'd0);
      chk({tag, "_active"}, {31'd0, ConfigActive}, 32'd0);
      chk({tag, "_oe"}, {31'd0, OutputEnable}, 32'd0);
      chk({tag, "_err"}, {31'd0, ConfigError}, 32'd0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      cks         = 32'd0;
      resetn      = 1'b1;
      WriteData   = 32'd0;
      WriteStrobe = 1'b0;
      #2 resetn = 1'b0;
      #1 chk_all_zero("reset");
      @(negedge UserCLK);
      @(negedge UserCLK);
      resetn = 1'b1;
      idle(2);
      chk_all_zero("post_reset");

      // Basic frame.
      open_session();
      chk("active_after_sync", {31'd0, ConfigActive}, 32'd1);
      chk("oe_after_sync", {31'd0, OutputEnable}, 32'd0);
      word(32'h0003_0002);
      push(8'd3, 5'd2, 32'hDEAD_BEEF);
      word(32'hDEAD_BEEF);
      idle(3);
      chk("hold_strobe", {31'd0, FrameStrobe}, 32'd0);
      chk("hold_data", FrameData, 32'hDEAD_BEEF);
      chk("hold_col", {24'd0, FrameCol}, 32'd3);
      chk("hold_idx", {27'd0, FrameIdx}, 32'd2);

      // Last legal index, and the sync word carried as ordinary data.
      word(32'h0005_0013);
      push(8'd5, 5'd19, SYNC);
      word(SYNC);
      chk("active_sync_as_data", {31'd0, ConfigActive}, 32'd1);

      // Back-to-back pairs, one frame every two cycles.
      word(32'h000A_0001);
      push(8'd10, 5'd1, 32'h1234_5678);
      word(32'h1234_5678);
      word(32'h00FF_0000);
      push(8'd255, 5'd0, 32'hA5A5_A5A5);
      word(32'hA5A5_A5A5);
      end_session(1'b1, 1'b0);

      // Outside a session pairs are ignored.
      send(32'h0003_0002);
      send(32'h0BAD_F00D);
      chk("idle_ignore_active", {31'd0, ConfigActive}, 32'd0);
      chk("idle_ignore_oe", {31'd0, OutputEnable}, 32'd1);

      // Out-of-range index sets the error, next pair still works.
      open_session();
      chk("oe_drop_on_sync", {31'd0, OutputEnable}, 32'd0);
      word(32'h0001_0014);
      word(32'h1111_1111);
      chk("err_bad_idx", {31'd0, ConfigError}, 32'd1);
      chk("data_hold_bad_idx", FrameData, 32'hA5A5_A5A5);
      word(32'h0002_0001);
      push(8'd2, 5'd1, 32'h0000_0055);
      word(32'h0000_0055);
      chk("err_sticky", {31'd0, ConfigError}, 32'd1);
      end_session(1'b0, 1'b1);

      // New session clears the error; clean close raises outputs.
      open_session();
      chk("err_clear_on_sync", {31'd0, ConfigError}, 32'd0);
      word(32'h0007_0004);
      push(8'd7, 5'd4, 32'h0F0F_0F0F);
      word(32'h0F0F_0F0F);
      end_session(1'b1, 1'b0);

`ifdef FRAME_CFG_CHECKSUM_EN
      // Explicit checksum match and mismatch.
      open_session();
      word(32'h0001_0000);
      push(8'd1, 5'd0, 32'h0000_00FF);
      word(32'h0000_00FF);
      send(32'h8000_0000);
      send(32'h0001_00FF);
      chk("cks_match_oe", {31'd0, OutputEnable}, 32'd1);
      chk("cks_match_err", {31'd0, ConfigError}, 32'd0);
      open_session();
      word(32'h0001_0000);
      push(8'd1, 5'd0, 32'h0000_00FF);
      word(32'h0000_00FF);
      send(32'h8000_0000);
      send(32'h0000_0000);
      chk("cks_bad_oe", {31'd0, OutputEnable}, 32'd0);
      chk("cks_bad_err", {31'd0, ConfigError}, 32'd1);
`endif

      // Reset while waiting for data abandons the session.
      open_session();
      word(32'h0004_0003);
      #2 resetn = 1'b0;
      #1 chk_all_zero("mid_reset");
      @(negedge UserCLK);
      resetn = 1'b1;
      send(32'h0000_CAFE);
      idle(2);
      chk_all_zero("after_reset_data");

      idle(3);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_config_fsm.md
FRAME_CONFIG_FSM -- requirements
Module: frame_config_fsm

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, frame data width delivered to the fabric column.
REQ-002 SHALL have parameter MaxFramesPerCol, default 20, number of legal frame indices per column (0..MaxFramesPerCol-1).
REQ-003 SHALL have parameter SyncWord, default 32'hFAB0_FAB1, word that opens a configuration session.
REQ-004 UserCLK  input  1  configuration/user clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 WriteData  input  32  configuration word.
REQ-007 WriteStrobe  input  1  WriteData valid this cycle; no backpressure, one word per cycle accepted.
REQ-008 FrameData  output  FrameBitsPerRow  registered frame payload.
REQ-009 FrameCol  output  8  registered target column.
REQ-010 FrameIdx  output  5  registered frame index within column.
REQ-011 FrameStrobe  output  1  one-cycle pulse: FrameData/FrameCol/FrameIdx valid.
REQ-012 ConfigActive  output  1  high while a session is open.
REQ-013 OutputEnable  output  1  global output enable to LUT/BEL output buffers; high only when fabric is validly configured.
REQ-014 ConfigError  output  1  sticky error flag.

Function
REQ-015 States SHALL be IDLE, ADDR, DATA, and CHECK (CHECK present only with FRAME_CFG_CHECKSUM_EN).
REQ-016 Words without WriteStrobe SHALL be ignored in every state; state holds.
REQ-017 IDLE: WriteData==SyncWord SHALL go to ADDR, set ConfigActive=1, OutputEnable=0, ConfigError=0, clear checksum; other words ignored.
REQ-018 ADDR: word with bit31=0 SHALL latch column=[23:16], index=[4:0] and go to DATA.
REQ-019 ADDR: word with bit31=1 SHALL be the desync word; go to CHECK (macro on) or IDLE with ConfigActive=0, OutputEnable=1 (macro off).
REQ-020 DATA: word SHALL be driven on FrameData with latched column/index, FrameStrobe=1 in the cycle after WriteStrobe (latency 1); next state ADDR.
REQ-021 DATA with latched index >= MaxFramesPerCol SHALL suppress FrameStrobe and set ConfigError=1; FSM still returns to ADDR.
REQ-022 FrameData SHALL take WriteData[FrameBitsPerRow-1:0]; upper bits ignored.
REQ-023 Back-to-back words every cycle SHALL be accepted; an addr/data pair every 2 cycles gives a FrameStrobe every 2 cycles.
REQ-024 FrameData/FrameCol/FrameIdx SHALL hold last values when FrameStrobe=0.
REQ-025 SyncWord received outside IDLE SHALL be treated as an ordinary word for that state (no restart).

Reset
REQ-026 resetn low SHALL asynchronously force IDLE, FrameStrobe=0, FrameData=0, FrameCol=0, FrameIdx=0, ConfigActive=0, OutputEnable=0, ConfigError=0, checksum=0.
REQ-027 Reset mid-session SHALL abandon the session; no FrameStrobe after reset until a new SyncWord and addr/data pair.

Configuration
REQ-028 Macro FRAME_CFG_CHECKSUM_EN defined: running XOR of every addr and data word after SyncWord (desync excluded); CHECK compares next word to it; match -> IDLE, OutputEnable=1; mismatch -> IDLE, ConfigError=1, OutputEnable=0.
REQ-029 Macro undefined: no checksum register, no CHECK state; desync goes straight to IDLE per REQ-019.
REQ-030 OutputEnable SHALL never rise while ConfigError=1.

Structure
REQ-031 Shared package SHALL hold the state enum, SyncWord default, desync bit position (31), and address field positions.
REQ-032 One sub-module, frame_cfg_checksum (XOR accumulator with clear/enable), SHALL be instantiated only under FRAME_CFG_CHECKSUM_EN.

Verification
REQ-033 Reset, then SyncWord, addr 32'h0003_0002, data 32'hDEAD_BEEF -> one cycle FrameStrobe=1, FrameCol=3, FrameIdx=2, FrameData=32'hDEADBEEF.
REQ-034 Macro off: SyncWord, one pair, 32'h8000_0000 -> ConfigActive 1->0, OutputEnable=1 the cycle after desync.
REQ-035 Macro on: SyncWord, addr 32'h0001_0000, data 32'h0000_00FF, desync, checksum 32'h0001_00FF -> OutputEnable=1; checksum 32'h0 instead -> ConfigError=1, OutputEnable=0.
REQ-036 Addr with index 20 (MaxFramesPerCol=20) then data -> no FrameStrobe, ConfigError=1, next addr accepted normally.
REQ-037 Assert resetn low while in DATA, release, send data word without SyncWord -> no FrameStrobe, state IDLE, all outputs 0.
